// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative HI/LO multiply/divide unit beside the execute-stage ALU.
// Handles MULT, MULTU, DIV, DIVU (shift-add / restoring divide, one bit per cycle)
// and MTHI/MTLO. busy_o tells the hazard unit to stall HI/LO readers and new ops.
// Optional build macro: MIPS_MULDIV_FAST_MUL_EN -- MULT/MULTU use a single-cycle
// array multiply (IDLE -> FIX directly); DIV/DIVU stay iterative.

module mips_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [5:0]            funct_i,
    input  logic [DATA_WIDTH-1:0] rs_data_i,
    input  logic [DATA_WIDTH-1:0] rt_data_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_WIDTH - 1);

    // R-type funct codes the unit reacts to
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, acc_d;        // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [W-1:0]   mag_b_q, mag_b_d;    // multiplicand or divisor magnitude
    logic           sign_q, sign_d;      // product / quotient sign
    logic           rem_sign_q, rem_sign_d;
    logic           is_div_q, is_div_d;
    logic           div_zero_q, div_zero_d;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic           done_q, done_d;

    logic           op_signed_s, rs_neg_s, rt_neg_s;
    logic [W-1:0]   rs_mag_s, rt_mag_s;
    logic [W:0]     mul_sum_s, div_rem_sh_s, div_diff_s;
    logic [2*W-1:0] mul_step_s, div_step_s, prod_s;
    logic [W-1:0]   quo_s, rem_s, fix_hi_s, fix_lo_s;

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    // Split incoming operands into sign and magnitude (signed ops only)
    always_comb begin
        op_signed_s = (funct_i == FN_MULT) || (funct_i == FN_DIV);
        rs_neg_s    = op_signed_s & rs_data_i[W-1];
        rt_neg_s    = op_signed_s & rt_data_i[W-1];
        if (rs_neg_s) begin
            rs_mag_s = {W{1'b0}} - rs_data_i;
        end else begin
            rs_mag_s = rs_data_i;
        end
        if (rt_neg_s) begin
            rt_mag_s = {W{1'b0}} - rt_data_i;
        end else begin
            rt_mag_s = rt_data_i;
        end
    end

    // One shift-add multiply step and one restoring divide step on the accumulator
    always_comb begin
        if (acc_q[0]) begin
            mul_sum_s = {1'b0, acc_q[2*W-1:W]} + {1'b0, mag_b_q};
        end else begin
            mul_sum_s = {1'b0, acc_q[2*W-1:W]};
        end
        mul_step_s   = {mul_sum_s, acc_q[W-1:1]};
        div_rem_sh_s = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff_s   = div_rem_sh_s - {1'b0, mag_b_q};
        if (div_diff_s[W]) begin
            div_step_s = {div_rem_sh_s[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
            div_step_s = {div_diff_s[W-1:0], acc_q[W-2:0], 1'b1};
        end
    end

    // Apply result signs to the finished magnitude; divide-by-zero forces LO to all ones
    always_comb begin
        if (sign_q) begin
            prod_s = {(2*W){1'b0}} - acc_q;
            quo_s  = {W{1'b0}} - acc_q[W-1:0];
        end else begin
            prod_s = acc_q;
            quo_s  = acc_q[W-1:0];
        end
        if (rem_sign_q) begin
            rem_s = {W{1'b0}} - acc_q[2*W-1:W];
        end else begin
            rem_s = acc_q[2*W-1:W];
        end
        if (is_div_q) begin
            fix_hi_s = rem_s;
            if (div_zero_q) begin
                fix_lo_s = {W{1'b1}};
            end else begin
                fix_lo_s = quo_s;
            end
        end else begin
            fix_hi_s = prod_s[2*W-1:W];
            fix_lo_s = prod_s[W-1:0];
        end
    end

    // FSM next-state: accept ops in IDLE, iterate, then commit HI/LO in FIX
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mag_b_d    = mag_b_q;
        sign_d     = sign_q;
        rem_sign_d = rem_sign_q;
        is_div_d   = is_div_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_i && !abort_i) begin
                    case (funct_i)
                        FN_MULT, FN_MULTU: begin
                            mag_b_d    = rs_mag_s;
                            sign_d     = rs_neg_s ^ rt_neg_s;
                            rem_sign_d = 1'b0;
                            is_div_d   = 1'b0;
                            div_zero_d = 1'b0;
                            cnt_d      = CNT_LOAD;
`ifdef MIPS_MULDIV_FAST_MUL_EN
                            acc_d      = {{W{1'b0}}, rs_mag_s} * {{W{1'b0}}, rt_mag_s};
                            state_d    = ST_FIX;
`else
                            acc_d      = {{W{1'b0}}, rt_mag_s};
                            state_d    = ST_MUL;
`endif
                        end
                        FN_DIV, FN_DIVU: begin
                            acc_d      = {{W{1'b0}}, rs_mag_s};
                            mag_b_d    = rt_mag_s;
                            sign_d     = rs_neg_s ^ rt_neg_s;
                            rem_sign_d = rs_neg_s;
                            is_div_d   = 1'b1;
                            div_zero_d = (rt_data_i == {W{1'b0}});
                            cnt_d      = CNT_LOAD;
                            state_d    = ST_DIV;
                        end
                        FN_MTHI: hi_d = rs_data_i;
                        FN_MTLO: lo_d = rs_data_i;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    if (state_q == ST_MUL) begin
                        acc_d = mul_step_s;
                    end else begin
                        acc_d = div_step_s;
                    end
                    if (cnt_q == {CW{1'b0}}) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (abort_i) begin
                    done_d = 1'b0;
                end else begin
                    hi_d   = fix_hi_s;
                    lo_d   = fix_lo_s;
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and HI/LO registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CW{1'b0}};
            acc_q      <= {(2*W){1'b0}};
            mag_b_q    <= {W{1'b0}};
            sign_q     <= 1'b0;
            rem_sign_q <= 1'b0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= {W{1'b0}};
            lo_q       <= {W{1'b0}};
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mag_b_q    <= mag_b_d;
            sign_q     <= sign_d;
            rem_sign_q <= rem_sign_d;
            is_div_q   <= is_div_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed vector table, hand-written
// multi-cycle sequences (busy-ignore, abort, reset mid-op) and random ops checked
// against an arithmetic reference model of HI/LO.

module tb_mips_muldiv_unit;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic [5:0]  funct_i = 6'h00;
    logic [31:0] rs_data_i = 32'h0;
    logic [31:0] rt_data_i = 32'h0;
    logic        abort_i = 1'b0;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl_hi = 32'h0;
    logic [31:0] mdl_lo = 32'h0;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;
    vec_t vecs[9];

    mips_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .funct_i(funct_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Architectural HI/LO effect of one op, from plain integer arithmetic
    task automatic ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f)
            F_MULT:  begin p = sa * sb; mdl_hi = p[63:32]; mdl_lo = p[31:0]; end
            F_MULTU: begin p = ua * ub; mdl_hi = p[63:32]; mdl_lo = p[31:0]; end
            F_DIV: begin
                if (b == 32'h0) begin
                    mdl_lo = 32'hFFFF_FFFF; mdl_hi = a;
                end else begin
                    sq = sa / sb; sr = sa % sb;
                    mdl_lo = sq[31:0]; mdl_hi = sr[31:0];
                end
            end
            F_DIVU: begin
                if (b == 32'h0) begin
                    mdl_lo = 32'hFFFF_FFFF; mdl_hi = a;
                end else begin
                    uq = ua / ub; ur = ua % ub;
                    mdl_lo = uq[31:0]; mdl_hi = ur[31:0];
                end
            end
            F_MTHI:  mdl_hi = a;
            F_MTLO:  mdl_lo = a;
            default: ;
        endcase
    endtask

    function automatic int exp_lat(input logic [5:0] f);
`ifdef MIPS_MULDIV_FAST_MUL_EN
        if (f == F_MULT || f == F_MULTU) return 2;
`endif
        return 34;
    endfunction

    function automatic bit is_muldiv(input logic [5:0] f);
        return (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU);
    endfunction

    // Present one op for one cycle; returns #1 into cycle 1
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid_i = 1'b1; funct_i = f; rs_data_i = a; rt_data_i = b;
        @(posedge clk);
        #1;
        valid_i = 1'b0; funct_i = 6'h00;
    endtask

    // Sample at negedges from cycle c0 until done_o (bounded); busy must hold until then
    task automatic wait_done(input int c0, output int lat, output int busy_err);
        lat = -1;
        busy_err = 0;
        for (int c = c0; c <= c0 + 45; c++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                lat = c;
                break;
            end
            if (busy_o !== 1'b1) busy_err++;
        end
    endtask

    // Finish checks after done_o sampled: busy low, HI/LO vs model, pulse one cycle wide
    task automatic check_result(input logic [5:0] f, input int lat, input int busy_err);
        check("latency", 64'(lat), 64'(exp_lat(f)));
        check("busy_window", 64'(busy_err), 64'd0);
        check("busy_at_done", {63'd0, busy_o}, 64'd0);
        check("hi", {32'd0, hi_o}, {32'd0, mdl_hi});
        check("lo", {32'd0, lo_o}, {32'd0, mdl_lo});
        @(negedge clk);
        check("done_pulse", {63'd0, done_o}, 64'd0);
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int lat, be;
        issue(f, a, b);
        ref_op(f, a, b);
        if (is_muldiv(f)) begin
            wait_done(1, lat, be);
            check_result(f, lat, be);
        end else begin
            check("idle_busy", {62'd0, busy_o, done_o}, 64'd0);
            check("hi", {32'd0, hi_o}, {32'd0, mdl_hi});
            check("lo", {32'd0, lo_o}, {32'd0, mdl_lo});
        end
    endtask

    initial begin
        int lat, be, dones;
        logic [5:0]  fsel[7];
        logic [31:0] a, b;

        vecs[0] = '{F_MULT,  32'hFFFF_FFFF, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[1] = '{F_MULTU, 32'hFFFF_FFFF, 32'h3,         32'h0000_0002, 32'hFFFF_FFFD};
        vecs[2] = '{F_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{F_DIVU,  32'h7,         32'h0,         32'h0000_0007, 32'hFFFF_FFFF};
        vecs[4] = '{F_DIV,   32'h7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[5] = '{F_DIV,   32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6] = '{F_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[7] = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8] = '{F_DIVU,  32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF};
        fsel = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_ADD};

        // reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", {30'd0, busy_o, done_o, hi_o}, 64'd0);
        check("reset_lo", {32'd0, lo_o}, 64'd0);
        rst_n = 1'b1;

        // directed vector table with constant expectations
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b);
            mdl_hi = vecs[i].hi;
            mdl_lo = vecs[i].lo;
            wait_done(1, lat, be);
            check_result(vecs[i].f, lat, be);
        end

        // signed overflow divide, with a MULT presented while busy (must be ignored)
        issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        @(negedge clk);
        valid_i = 1'b1; funct_i = F_MULT; rs_data_i = 32'h2; rt_data_i = 32'h3;
        @(negedge clk);
        valid_i = 1'b0; funct_i = 6'h00;
        mdl_hi = 32'h0; mdl_lo = 32'h8000_0000;
        wait_done(3, lat, be);
        check_result(F_DIV, lat, be);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        check("ignored_op_done", 64'(dones), 64'd0);
        check("ignored_op_hilo", {hi_o, lo_o}, {32'h0, 32'h8000_0000});

        // abort in IDLE drops a same-cycle op
        @(negedge clk);
        valid_i = 1'b1; abort_i = 1'b1; funct_i = F_MTHI; rs_data_i = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        valid_i = 1'b0; abort_i = 1'b0; funct_i = 6'h00;
        check("idle_abort_hi", {32'd0, hi_o}, 64'h0);

        // MTHI then MULT aborted at cycle 10
        run_op(F_MTHI, 32'h1234_5678, 32'h0);
        issue(F_MULT, 32'h5, 32'h6);
`ifdef MIPS_MULDIV_FAST_MUL_EN
        ref_op(F_MULT, 32'h5, 32'h6);
`endif
        repeat (9) @(posedge clk);
        #1;
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        check("abort_busy", {63'd0, busy_o}, 64'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        check("abort_done", 64'(dones), 64'd0);
        check("abort_hilo", {hi_o, lo_o}, {mdl_hi, mdl_lo});

        // asynchronous reset during cycle 20 of a DIV
        issue(F_DIV, 32'd100, 32'd7);
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midop_reset", {30'd0, busy_o, done_o, hi_o}, 64'd0);
        check("midop_reset_lo", {32'd0, lo_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mdl_hi = 32'h0; mdl_lo = 32'h0;
        run_op(F_MTLO, 32'hA5A5_A5A5, 32'h0);

        // random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            run_op(fsel[$urandom_range(0, 6)], a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // absolute time limit so the bench can never hang
    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end
endmodule
